// File: rtl/cbus_arbiter.sv
// cbus_arbiter: round-robin arbiter that shares one cache-bus master port
// between NUM_INPUTS requesters (default: port 0 = data, port 1 = fetch).
// A grant is held for a whole (possibly multi-beat) transaction and is
// released on the beat carrying oresp.ready && oresp.last.
//
// Ports
//   clk     in   clock, rising edge
//   reset   in   synchronous active-high reset
//   ireqs   in   per-requester cache-bus requests
//   iresps  out  per-requester responses (all-zero unless granted)
//   oreq    out  request forwarded to the bus / AXI bridge
//   oresp   in   response from the bus / AXI bridge

package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_INPUTS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireqs  [NUM_INPUTS],
  output cbus_resp_t iresps [NUM_INPUTS],
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);

  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  // One extra bit so ptr + offset never overflows before the wrap.
  localparam int SUM_W = IDX_W + 1;

  logic             r_busy;
  logic [IDX_W-1:0] r_index;
  logic [IDX_W-1:0] r_ptr;

  logic             w_busy_nxt;
  logic [IDX_W-1:0] w_index_nxt;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic             w_found;
  logic [IDX_W-1:0] w_win;
  logic [SUM_W-1:0] w_sum;
  logic [IDX_W-1:0] w_scan;

  // State register: busy/index/ptr
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_index <= '0;
      r_ptr   <= '0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_index <= w_index_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Next-state: arbitration in IDLE, release on the last beat in BUSY
  always_comb begin
    w_busy_nxt  = r_busy;
    w_index_nxt = r_index;
    w_ptr_nxt   = r_ptr;
    w_found     = 1'b0;
    w_win       = r_index;
    w_sum       = '0;
    w_scan      = '0;

    if (!r_busy) begin
      // Scan ptr, ptr+1, ... wrapping at NUM_INPUTS; first valid port wins.
      for (int i = 0; i < NUM_INPUTS; i++) begin
        w_sum = {1'b0, r_ptr} + SUM_W'(i);
        if (w_sum >= SUM_W'(NUM_INPUTS)) begin
          w_sum = w_sum - SUM_W'(NUM_INPUTS);
        end
        w_scan = w_sum[IDX_W-1:0];
        if (!w_found && ireqs[w_scan].valid) begin
          w_found = 1'b1;
          w_win   = w_scan;
        end
      end
      if (w_found) begin
        w_busy_nxt  = 1'b1;
        w_index_nxt = w_win;
      end
    end else if (oresp.ready && oresp.last) begin
      // The port just served drops to lowest priority.
      w_busy_nxt = 1'b0;
      w_ptr_nxt  = (r_index == IDX_W'(NUM_INPUTS - 1)) ? '0 : r_index + 1'b1;
    end
  end

  // Outputs: pure routing, nothing is buffered. In IDLE the bus sees zeros,
  // so there is no combinational path from ireqs to oreq until granted.
  always_comb begin
    oreq = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      iresps[k] = '0;
    end
    if (r_busy) begin
      oreq            = ireqs[r_index];
      iresps[r_index] = oresp;
    end
  end

endmodule
